// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider.
package div_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam int DIV_WIDTH = 32;
  localparam logic [DIV_WIDTH-1:0] DIV0_QUOTIENT = '1;
  localparam logic [DIV_WIDTH-1:0] SIGNED_MIN = {1'b1, {(DIV_WIDTH-1){1'b0}}};

  // Unsigned magnitude; MIN maps to 2^(W-1), which is representable unsigned.
  function automatic logic [DIV_WIDTH-1:0] magnitude(input logic [DIV_WIDTH-1:0] value,
                                                     input logic is_signed);
    return (is_signed && value[DIV_WIDTH-1]) ? -value : value;
  endfunction

endpackage

// File: rtl/add_32.sv
// Ripple-style adder shared with the ALU; the divider uses it as a subtractor.
module add_32 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             i_carry,
  output logic [WIDTH-1:0] sum,
  output logic             o_carry
);

  assign {o_carry, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, i_carry};

endmodule

// File: rtl/div_step.sv
// One combinational restoring-division step: shift, trial subtract, select.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_next,
  output logic             q_bit
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH-1:0] diff;
  logic             carry;

  assign shifted = {rem, dividend_bit};

  add_32 #(.WIDTH(WIDTH)) u_sub (
    .a       (shifted[WIDTH-1:0]),
    .b       (~divisor),
    .i_carry (1'b1),
    .sum     (diff),
    .o_carry (carry)
  );

  // A set bit above the adder width means the shifted value already exceeds the divisor.
  assign q_bit    = carry | (|shifted[WIDTH+1:WIDTH]);
  assign rem_next = q_bit ? {1'b0, diff} : shifted[WIDTH:0];

endmodule

// File: rtl/div_32_seq.sv
// Multi-cycle signed/unsigned restoring divider with valid/ready on both sides.
// Optional macro DIV_EARLY_OUT_EN: finish in one cycle when |divisor| > |dividend|.
module div_32_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  input  logic             i_signed,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_div_by_zero,
  output logic             o_overflow
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both high;
  // the source holds its payload until then and may not retract it.

  localparam int CW = $clog2(WIDTH);

  state_t           state, state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] divisor_mag;
  logic             neg_q, neg_r;

  logic [WIDTH-1:0] dividend_abs, divisor_abs;
  logic             accept, is_div0, is_ovf, is_early;
  logic [WIDTH:0]   step_rem;
  logic             step_bit;
  logic [WIDTH-1:0] quo_next, q_final, r_final;

  assign o_ready = (state == IDLE);
  assign o_valid = (state == DONE);
  assign accept  = i_valid && o_ready;

  assign dividend_abs = magnitude(i_dividend, i_signed);
  assign divisor_abs  = magnitude(i_divisor, i_signed);
  assign is_div0      = (i_divisor == '0);
  assign is_ovf       = i_signed && (i_dividend == SIGNED_MIN) && (i_divisor == '1);
`ifdef DIV_EARLY_OUT_EN
  assign is_early = !is_div0 && !is_ovf && (divisor_abs > dividend_abs);
`else
  assign is_early = 1'b0;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem          (rem),
    .dividend_bit (quo[WIDTH-1]),
    .divisor      (divisor_mag),
    .rem_next     (step_rem),
    .q_bit        (step_bit)
  );

  // quo doubles as the dividend shift register: dividend bits leave at the top
  // while quotient bits enter at the bottom.
  assign quo_next = {quo[WIDTH-2:0], step_bit};
  assign q_final  = neg_q ? -quo_next : quo_next;
  assign r_final  = neg_r ? -step_rem[WIDTH-1:0] : step_rem[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = (is_div0 || is_ovf || is_early) ? DONE : CALC;
      CALC:    if (cnt == '0) state_next = DONE;
      DONE:    if (i_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt           <= '0;
      rem           <= '0;
      quo           <= '0;
      divisor_mag   <= '0;
      neg_q         <= 1'b0;
      neg_r         <= 1'b0;
      o_quotient    <= '0;
      o_remainder   <= '0;
      o_div_by_zero <= 1'b0;
      o_overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cnt           <= CW'(WIDTH - 1);
            rem           <= '0;
            quo           <= dividend_abs;
            divisor_mag   <= divisor_abs;
            neg_q         <= i_signed && (i_dividend[WIDTH-1] ^ i_divisor[WIDTH-1]);
            neg_r         <= i_signed && i_dividend[WIDTH-1];
            o_div_by_zero <= 1'b0;
            o_overflow    <= 1'b0;
            if (is_div0) begin
              o_quotient    <= DIV0_QUOTIENT;
              o_remainder   <= i_dividend;
              o_div_by_zero <= 1'b1;
            end else if (is_ovf) begin
              o_quotient  <= SIGNED_MIN;
              o_remainder <= '0;
              o_overflow  <= 1'b1;
            end else if (is_early) begin
              o_quotient  <= '0;
              o_remainder <= i_dividend;
            end
          end
        end
        CALC: begin
          rem <= step_rem;
          quo <= quo_next;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            o_quotient  <= q_final;
            o_remainder <= r_final;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_32_seq.sv
// Randomized self-checking bench for div_32_seq with a plain-arithmetic model.
module tb_div_32_seq;

  localparam int W  = 32;
  localparam int EW = 2 * W + 2 + 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_valid, i_ready, i_signed;
  logic          o_ready, o_valid, o_div_by_zero, o_overflow;
  logic [W-1:0]  i_dividend, i_divisor, o_quotient, o_remainder;

  logic [EW-1:0] exp_q[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            acc = 0;
  logic          prev_valid = 1'b0;

  div_32_seq dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_valid       (i_valid),
    .o_ready       (o_ready),
    .i_dividend    (i_dividend),
    .i_divisor     (i_divisor),
    .i_signed      (i_signed),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_quotient    (o_quotient),
    .o_remainder   (o_remainder),
    .o_div_by_zero (o_div_by_zero),
    .o_overflow    (o_overflow)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Expected {quotient, remainder, div_by_zero, overflow, latency}.
  function automatic logic [EW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic s);
    logic [W-1:0] q, r;
    logic         dz, ov;
    logic [7:0]   lat;
    longint       sa, sb;
    dz = 1'b0; ov = 1'b0; lat = 8'd33;
    sa = s ? longint'($signed(a)) : longint'(a);
    sb = s ? longint'($signed(b)) : longint'(b);
    if (sa < 0) sa = -sa;
    if (sb < 0) sb = -sb;
    if (b == 0) begin
      q = '1; r = a; dz = 1'b1; lat = 8'd1;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = '0; ov = 1'b1; lat = 8'd1;
    end else begin
      if (s) begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end else begin
        q = a / b;
        r = a % b;
      end
`ifdef DIV_EARLY_OUT_EN
      if (sb > sa) lat = 8'd1;
`endif
    end
    return {q, r, dz, ov, lat};
  endfunction

  // scoreboard: compare outputs on every cycle a result is presented
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (i_valid && o_ready) acc = cyc;
      if (o_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_valid", {79'd0, o_valid}, 80'd0);
        end else begin
          chk("quotient", {48'd0, o_quotient}, {48'd0, exp_q[0][EW-1:EW-W]});
          chk("remainder", {48'd0, o_remainder}, {48'd0, exp_q[0][EW-W-1:10]});
          chk("div_by_zero", {79'd0, o_div_by_zero}, {79'd0, exp_q[0][9]});
          chk("overflow", {79'd0, o_overflow}, {79'd0, exp_q[0][8]});
          chk("ready_busy", {79'd0, o_ready}, 80'd0);
          if (!prev_valid) chk("latency", 80'(cyc - acc), {72'd0, exp_q[0][7:0]});
          if (i_ready) void'(exp_q.pop_front());
        end
      end
      prev_valid = o_valid;
    end
  end

  // driver: one full transaction with optional back-pressure
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input int hold);
    int n;
    n = 0;
    while (!o_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (!o_ready) begin
      checks++; errors++;
      $display("FAIL ready_timeout actual=0 required=1");
      return;
    end
    i_dividend = a; i_divisor = b; i_signed = s; i_valid = 1'b1;
    exp_q.push_back(model(a, b, s));
    @(posedge clk); #1;
    i_valid = 1'b0; i_dividend = $urandom; i_divisor = $urandom;
    i_signed = 1'($urandom_range(0, 1));
    n = 0;
    while (!o_valid && n < 60) begin @(posedge clk); #1; n++; end
    if (!o_valid) begin
      checks++; errors++;
      $display("FAIL result_timeout actual=0 required=1");
      exp_q.delete();
      return;
    end
    repeat (hold) begin @(posedge clk); #1; end
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b0;
    chk("ready_after", {79'd0, o_ready}, 80'd1);
    chk("valid_after", {79'd0, o_valid}, 80'd0);
  endtask

  initial begin
    logic [W-1:0] a, b;
    logic         s;
    int           kind;
    rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
    i_dividend = '0; i_divisor = '0; i_signed = 1'b0;

    // model pinned to hand-computed values
    chk("pin_432_123", 80'(model(32'd432, 32'd123, 1'b0)), 80'({32'd3, 32'd63, 2'b00, 8'd33}));
`ifdef DIV_EARLY_OUT_EN
    chk("pin_1123_1312", 80'(model(32'd1123, 32'd1312, 1'b0)), 80'({32'd0, 32'd1123, 2'b00, 8'd1}));
`else
    chk("pin_1123_1312", 80'(model(32'd1123, 32'd1312, 1'b0)), 80'({32'd0, 32'd1123, 2'b00, 8'd33}));
`endif
    chk("pin_m7_2", 80'(model(-32'sd7, 32'd2, 1'b1)), 80'({32'hFFFF_FFFD, 32'hFFFF_FFFF, 2'b00, 8'd33}));
    chk("pin_7_m2", 80'(model(32'd7, -32'sd2, 1'b1)), 80'({32'hFFFF_FFFD, 32'd1, 2'b00, 8'd33}));
    chk("pin_div0", 80'(model(32'd123, 32'd0, 1'b1)), 80'({32'hFFFF_FFFF, 32'd123, 2'b10, 8'd1}));
    chk("pin_ovf", 80'(model(32'h8000_0000, 32'hFFFF_FFFF, 1'b1)), 80'({32'h8000_0000, 32'd0, 2'b01, 8'd1}));
    chk("pin_1312_421", 80'(model(32'd1312, 32'd421, 1'b0)), 80'({32'd3, 32'd49, 2'b00, 8'd33}));

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {79'd0, o_ready}, 80'd1);
    chk("rst_valid", {79'd0, o_valid}, 80'd0);
    chk("rst_q", {48'd0, o_quotient}, 80'd0);
    chk("rst_r", {48'd0, o_remainder}, 80'd0);
    chk("rst_flags", {78'd0, o_div_by_zero, o_overflow}, 80'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // directed cases
    run_op(32'd432, 32'd123, 1'b0, 0);
    run_op(32'd1123, 32'd1312, 1'b0, 0);
    run_op(-32'sd7, 32'd2, 1'b1, 0);
    run_op(32'd7, -32'sd2, 1'b1, 1);
    run_op(32'd123, 32'd0, 1'b0, 0);
    run_op(32'd123, 32'd0, 1'b1, 0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
    run_op(32'h8000_0000, 32'd1, 1'b1, 0);
    run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 10);

    // reset in the middle of a calculation
    i_dividend = 32'd100_000; i_divisor = 32'd7; i_signed = 1'b0; i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (16) begin @(posedge clk); #1; end
    chk("calc_ready", {79'd0, o_ready}, 80'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", {79'd0, o_ready}, 80'd1);
    chk("midrst_valid", {79'd0, o_valid}, 80'd0);
    chk("midrst_q", {48'd0, o_quotient}, 80'd0);
    chk("midrst_r", {48'd0, o_remainder}, 80'd0);
    chk("midrst_flags", {78'd0, o_div_by_zero, o_overflow}, 80'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_op(32'd1312, 32'd421, 1'b0, 0);

    // randomized operands with biased corner classes
    for (int i = 0; i < 200; i++) begin
      kind = $urandom_range(0, 9);
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom;
      case (kind)
        0: b = '0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; s = 1'b1; end
        2: b = W'($urandom_range(1, 20)) * (($urandom_range(0, 1) == 1) ? '1 : 32'd1);
        3: begin a = W'($urandom_range(0, 1000)); b = W'($urandom_range(1001, 5000)); end
        4: a = 32'h8000_0000;
        default: ;
      endcase
      run_op(a, b, s, $urandom_range(0, 3));
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
